// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: PC increment, reset vector,
// instruction width and the fetch-stage edge action.
package core_pkg;

  localparam int unsigned PC_INC = 4;
  localparam int unsigned INST_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // What the fetch stage does on the next rising edge, highest priority first.
  typedef enum logic [1:0] {
    FETCH_REDIRECT,
    FETCH_ADVANCE,
    FETCH_HOLD
  } fetch_action_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect and the
// IF/ID valid/ready handshake towards decode.
interface fetch_stage_if #(
  parameter int unsigned PC_W = 32
);

  logic [PC_W-1:0] imem_pc;
  logic [PC_W-1:0] imem_inst;
  logic            br_taken;
  logic [PC_W-1:0] br_addr;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_inst;
  logic [31:0]     fetch_count;

  // Seen from the fetch stage.
  modport master (
    output imem_pc,
    input  imem_inst,
    input  br_taken,
    input  br_addr,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    output fetch_count
  );

  // Seen from memory, execute and decode.
  modport slave (
    input  imem_pc,
    output imem_inst,
    output br_taken,
    output br_addr,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: +4 sequencing, branch redirect with word alignment.
import core_pkg::*;

module fetch_pc_reg #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_addr,
  output logic [PC_W-1:0] pc
);

  // Clears the two byte-offset bits of a redirect target.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(PC_INC - 1);

  logic [PC_W-1:0] pc_q;

  // Redirect beats sequential advance; otherwise the PC holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (br_taken) begin
      pc_q <= br_addr & ALIGN_MASK;
    end else if (advance) begin
      pc_q <= pc_q + PC_W'(PC_INC);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory from the PC and
// presents each fetched word to decode through a one-entry IF/ID register.
import core_pkg::*;

module fetch_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.master bus
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            hold;
  logic            advance;
  fetch_action_e   action;

  logic            valid_q;
  logic [PC_W-1:0] out_pc_q;
  logic [PC_W-1:0] out_inst_q;
  logic [31:0]     count_q;

  // out_ready only reaches the PC through the advance enable, never imem_pc.
  assign hold    = valid_q && !bus.out_ready;
  assign advance = !hold;
  assign pc_next = pc + PC_W'(PC_INC);

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .br_taken (bus.br_taken),
    .br_addr  (bus.br_addr),
    .pc       (pc)
  );

  // Edge action: a redirect wins over both advance and hold.
  always_comb begin
    action = FETCH_ADVANCE;
    if (bus.br_taken) begin
      action = FETCH_REDIRECT;
    end else if (hold) begin
      action = FETCH_HOLD;
    end
  end

  // IF/ID register and fetch counter; payload keeps its last value when invalidated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      out_pc_q   <= '0;
      out_inst_q <= '0;
      count_q    <= '0;
    end else begin
      case (action)
        FETCH_REDIRECT: valid_q <= 1'b0;
        FETCH_ADVANCE: begin
          valid_q    <= 1'b1;
          out_pc_q   <= pc_next;
          out_inst_q <= bus.imem_inst;
          count_q    <= count_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_pc     = pc;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_inst    = out_inst_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random
// ready/branch traffic, all checked against a cycle-level reference model.
module tb_fetch_stage;

  logic clk;
  logic rst;

  fetch_stage_if #(.PC_W(32)) bus ();
  fetch_stage_if #(.PC_W(32)) wbus ();

  fetch_stage #(
    .PC_W     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_stage #(
    .PC_W     (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_inst  = mem_fn(bus.imem_pc);
  assign wbus.imem_inst = mem_fn(wbus.imem_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_opc;
  logic [31:0] m_oinst;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"},   {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk({tag, ".imem_pc"}, bus.imem_pc,            m_pc);
    chk({tag, ".out_pc"},  bus.out_pc,             m_opc);
    chk({tag, ".out_inst"}, bus.out_inst,          m_oinst);
    chk({tag, ".count"},   bus.fetch_count,        m_cnt);
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_opc   = 32'h0;
    m_oinst = 32'h0;
    m_cnt   = 32'h0;
  endtask

  // Apply inputs for one cycle, advance the model at the edge, settle past it.
  task automatic step(input logic rdy, input logic br, input logic [31:0] addr);
    bus.out_ready = rdy;
    bus.br_taken  = br;
    bus.br_addr   = addr;
    @(posedge clk);
    if (br) begin
      m_pc    = {addr[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!(m_valid && !rdy)) begin
      m_oinst = mem_fn(m_pc);
      m_pc    = m_pc + 32'd4;
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.out_ready  = 1'b1;
    bus.br_taken   = 1'b0;
    bus.br_addr    = '0;
    wbus.out_ready = 1'b1;
    wbus.br_taken  = 1'b0;
    wbus.br_addr   = '0;
    model_reset();

    // Reset state, before any edge
    #1;
    chk_all("reset");
    chk("wrap.reset_imem_pc", wbus.imem_pc, 32'hFFFF_FFFC);
    chk("wrap.reset_valid", {31'd0, wbus.out_valid}, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    // Streaming with decode always ready
    step(1'b1, 1'b0, 32'h0);
    chk_all("stream1");
    chk("wrap.out_pc", wbus.out_pc, 32'h0);
    chk("wrap.imem_pc", wbus.imem_pc, 32'h0);
    chk("wrap.out_inst", wbus.out_inst, mem_fn(32'hFFFF_FFFC));
    chk("wrap.valid", {31'd0, wbus.out_valid}, 32'd1);
    step(1'b1, 1'b0, 32'h0);
    chk_all("stream2");
    step(1'b1, 1'b0, 32'h0);
    chk_all("stream3");
    chk("stream3.out_pc_is_12", bus.out_pc, 32'd12);

    // Three-cycle stall
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk_all("stall");
      chk("stall.imem_pc_12", bus.imem_pc, 32'd12);
    end
    step(1'b1, 1'b0, 32'h0);
    chk_all("resume");

    // Branch with decode ready
    step(1'b1, 1'b1, 32'h40);
    chk_all("branch.n1");
    chk("branch.imem_40", bus.imem_pc, 32'h40);
    step(1'b1, 1'b0, 32'h0);
    chk_all("branch.n2");
    chk("branch.out_pc_44", bus.out_pc, 32'h44);

    // Branch while holding, unaligned target
    step(1'b0, 1'b0, 32'h0);
    chk_all("pre_stall_br");
    step(1'b0, 1'b1, 32'h23);
    chk_all("stall_br");
    chk("stall_br.imem_20", bus.imem_pc, 32'h20);
    step(1'b1, 1'b0, 32'h0);
    chk_all("stall_br.next");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), $urandom);
      chk_all("random");
    end

    // Asynchronous reset mid-stream with a live instruction
    step(1'b1, 1'b0, 32'h0);
    chk_all("pre_async");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all("async_reset");
    chk("wrap.async_imem_pc", wbus.imem_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), $urandom);
      chk_all("post_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core. Holds the program counter, drives the word-addressed instruction memory's `pc` input, captures the returned instruction, and presents it to decode through a one-entry IF/ID register with a valid/ready handshake. Branch redirects from the execute stage flush the IF/ID register and reload the PC.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.
- `PC_W`, default 32: PC and instruction width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_pc`  out  PC_W  address to the instruction memory. Combinational copy of the PC register.
- `imem_inst`  in  PC_W  instruction from the instruction memory. Combinational, valid in the same cycle as `imem_pc`.
- `br_taken`  in  1  redirect request from execute.
- `br_addr`  in  PC_W  redirect target.
- `out_valid`  out  1  IF/ID register holds a live instruction.
- `out_ready`  in  1  decode accepts the instruction this cycle.
- `out_pc`  out  PC_W  address of the held instruction + 4, following the lab's IF/ID convention.
- `out_inst`  out  PC_W  held instruction word.
- `fetch_count`  out  32  count of fetches accepted into IF/ID, for debug.

## Operation

- `hold = out_valid && !out_ready`
- `advance = !hold`
- `pc_next = pc + 4`, truncated to PC_W bits. Wraps from 32'hFFFF_FFFC to 0 with no flag.
- Edge priorities, highest first:
  1. `br_taken`:
     - `pc <= {br_addr[PC_W-1:2], 2'b00}`
     - `out_valid <= 0`, which discards any held instruction, accepted or not.
     - The instruction fetched this cycle is dropped.
     - `fetch_count` is unchanged.
     - `br_taken` is honoured regardless of `out_ready`.
  2. `advance`:
     - `pc <= pc_next`
     - `out_pc <= pc_next`
     - `out_inst <= imem_inst`
     - `out_valid <= 1`
     - `fetch_count <= fetch_count + 1`, wrapping.
  3. `hold`: PC and all IF/ID outputs keep their values.
- Reset, asserted at any time, takes effect immediately:
  - `pc = RESET_PC`
  - `out_valid = 0`, `out_pc = 0`, `out_inst = 0`, `fetch_count = 0`
  - `imem_pc` therefore reads RESET_PC during reset.
- Reset deassertion mid-stream: the first fetch is from RESET_PC on the first edge after `rst` falls. No other state survives reset.
- `out_pc` and `out_inst` are don't-care to decode when `out_valid = 0`, but they still hold their last values; they are not cleared.

## Timing

- Fetch latency: the instruction at `imem_pc` appears on `out_*` one cycle later.
- Throughput: one instruction per cycle while `out_ready = 1`.
- Handshake:
  - Transfer occurs on an edge where `out_valid && out_ready`.
  - While `hold`, `out_pc` and `out_inst` are stable.
  - `out_valid` does not drop without a transfer, except on branch or reset.
  - `out_ready` may be combinationally derived from anything except `out_valid`.
- Branch penalty: with `br_taken` at cycle N:
  - `out_valid = 0` in cycle N+1.
  - The target instruction is on `out_*` in cycle N+2, with `out_pc = target + 4`.
- Simultaneous `br_taken` and `hold`: branch wins and the held instruction is dropped.
- No combinational path from `out_ready` to `imem_pc`.

## Structure

- Shared package `core_pkg`:
  - `PC_INC = 4`
  - default `RESET_PC`
  - `INST_W = 32`
- Sub-module `fetch_pc_reg`: PC register, +4 adder, redirect mux and alignment masking. Inputs: `advance`, `br_taken`, `br_addr`. Output: `pc`.
- The IF/ID register and `fetch_count` live in the `fetch_stage` top.

## Test plan

- Reset release, `out_ready = 1`, memory returning `inst = pc`:
  - `imem_pc` steps 0, 4, 8, ...
  - `out_valid` first rises after edge 1.
  - `out_pc` is 4, 8, 12; `fetch_count` is 1, 2, 3.
- Stall: hold `out_ready = 0` for 3 cycles while `out_inst = I@8`.
  - `imem_pc` stays 12.
  - `out_pc = 12` and `out_inst` are stable.
  - `fetch_count` is frozen; fetching resumes on the cycle `out_ready` returns.
- Branch: `br_taken = 1`, `br_addr = 32'h40` at cycle N.
  - Cycle N+1: `out_valid = 0`, `imem_pc = 32'h40`.
  - Cycle N+2: `out_pc = 32'h44`.
- Branch during stall (`out_ready = 0`, `br_addr = 32'h23`):
  - Held instruction is dropped.
  - PC loads 32'h20, showing alignment masking.
- Wrap: `RESET_PC = 32'hFFFF_FFFC`.
  - `out_pc = 0` after the first fetch.
  - Next `imem_pc = 0`.
- Asynchronous reset mid-stream with `out_valid = 1`:
  - Outputs clear in the same cycle, before any clock edge.
  - `imem_pc = RESET_PC`.
